// File: rtl/spdif_sub_frame_decoder.sv
// Biphase-mark sub-frame decoder: locks onto B/M/W preambles spaced 64 half-cells
// apart and delivers each decoded 32-slot sub-frame as one word over valid/ready.
module spdif_sub_frame_decoder (
    input  logic        clk128,
    input  logic        reset_n,
    input  logic        spdif,
    input  logic        i_ready,
    output logic        o_valid,
    output logic [23:0] o_audio,
    output logic        o_is_frame_start,
    output logic        o_is_left,
    output logic        o_validity,
    output logic        o_user,
    output logic        o_control,
    output logic        o_parity_error,
    output logic        o_biphase_error,
    output logic        o_locked,
    output logic        o_overrun,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  hist;
    logic [5:0]  cnt;
    logic [26:0] slot_sr;
    logic        bp_err;
    logic        type_fs;
    logic        type_left;

    logic        word_done;
    logic [27:0] pend_slots;
    logic        pend_fs;
    logic        pend_left;
    logic        pend_bp;

    logic        cur;
    logic        prev;
    logic        cell_bit;
    logic [27:0] full_slots;
    logic        pre_hit;
    logic        pre_fs;
    logic        pre_left;

    // hist[0] is the single registered copy of spdif; hist[7] is the oldest half-cell.
    assign cur        = hist[0];
    assign prev       = hist[1];
    assign cell_bit   = cur ^ prev;
    assign full_slots = {cell_bit, slot_sr};
    assign o_state    = state;

    always_comb begin
        pre_hit  = 1'b0;
        pre_fs   = 1'b0;
        pre_left = 1'b0;
        case (hist)
            8'b11101000, 8'b00010111: begin
                pre_hit  = 1'b1;
                pre_fs   = 1'b1;
                pre_left = 1'b1;
            end
            8'b11100010, 8'b00011101: begin
                pre_hit  = 1'b1;
                pre_left = 1'b1;
            end
            8'b11100100, 8'b00011011: begin
                pre_hit  = 1'b1;
            end
            default: begin
                pre_hit  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk128 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HUNT;
            hist       <= 8'd0;
            cnt        <= 6'd0;
            slot_sr    <= 27'd0;
            bp_err     <= 1'b0;
            type_fs    <= 1'b0;
            type_left  <= 1'b0;
            o_locked   <= 1'b0;
            word_done  <= 1'b0;
            pend_slots <= 28'd0;
            pend_fs    <= 1'b0;
            pend_left  <= 1'b0;
            pend_bp    <= 1'b0;
        end else begin
            hist      <= {hist[6:0], spdif};
            word_done <= 1'b0;
            case (state)
                HUNT: begin
                    if (pre_hit) begin
                        state     <= DATA;
                        o_locked  <= 1'b1;
                        type_fs   <= pre_fs;
                        type_left <= pre_left;
                        cnt       <= 6'd0;
                        bp_err    <= 1'b0;
                    end
                end
                DATA: begin
                    cnt <= cnt + 6'd1;
                    // Even counts see a slot's first half-cell: it must differ from the one before.
                    if (!cnt[0]) begin
                        if (cur == prev) begin
                            bp_err <= 1'b1;
                        end
                    end else begin
                        slot_sr <= {cell_bit, slot_sr[26:1]};
                    end
                    if (cnt == 6'd55) begin
                        word_done  <= 1'b1;
                        pend_slots <= full_slots;
                        pend_fs    <= type_fs;
                        pend_left  <= type_left;
                        pend_bp    <= bp_err;
                        state      <= CHECK;
                        cnt        <= 6'd0;
                    end
                end
                CHECK: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd7) begin
                        cnt <= 6'd0;
                        if (pre_hit) begin
                            state     <= DATA;
                            type_fs   <= pre_fs;
                            type_left <= pre_left;
                            bp_err    <= 1'b0;
                        end else begin
                            state    <= HUNT;
                            o_locked <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

    // Handshake: a word transfers on any edge with o_valid && i_ready; while o_valid is
    // high and not accepted, every field holds. A word that completes against a stalled
    // output is dropped and flagged by a one-cycle o_overrun.
    always_ff @(posedge clk128 or negedge reset_n) begin
        if (!reset_n) begin
            o_valid          <= 1'b0;
            o_audio          <= 24'd0;
            o_is_frame_start <= 1'b0;
            o_is_left        <= 1'b0;
            o_validity       <= 1'b0;
            o_user           <= 1'b0;
            o_control        <= 1'b0;
            o_parity_error   <= 1'b0;
            o_biphase_error  <= 1'b0;
            o_overrun        <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (word_done && (!o_valid || i_ready)) begin
                o_valid          <= 1'b1;
                o_audio          <= pend_slots[23:0];
                o_validity       <= pend_slots[24];
                o_user           <= pend_slots[25];
                o_control        <= pend_slots[26];
                o_parity_error   <= ^pend_slots;
                o_biphase_error  <= pend_bp;
                o_is_frame_start <= pend_fs;
                o_is_left        <= pend_left;
            end else if (word_done) begin
                o_overrun <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spdif_sub_frame_decoder.sv
// Bench for spdif_sub_frame_decoder: a biphase-mark sub-frame generator drives the line,
// expected words are queued at send time and a negedge monitor pops and compares them.
module tb_spdif_sub_frame_decoder;

  localparam int W = 31;
  localparam logic [1:0] PT_B = 2'd0;
  localparam logic [1:0] PT_M = 2'd1;
  localparam logic [1:0] PT_W = 2'd2;

  logic        clk128 = 1'b0;
  logic        reset_n = 1'b0;
  logic        spdif = 1'b0;
  logic        i_ready = 1'b1;
  logic        o_valid;
  logic [23:0] o_audio;
  logic        o_is_frame_start;
  logic        o_is_left;
  logic        o_validity;
  logic        o_user;
  logic        o_control;
  logic        o_parity_error;
  logic        o_biphase_error;
  logic        o_locked;
  logic        o_overrun;
  logic [1:0]  o_state;

  logic [W-1:0]  exp_q[$];
  int unsigned   acc_cyc[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            ovr_cnt = 0;
  int unsigned   cyc = 0;
  logic          line_lvl = 1'b0;

  logic [W-1:0] dut_word;
  logic [33:0]  all_outs;

  assign dut_word = {o_biphase_error, o_parity_error, o_control, o_user, o_validity,
                     o_is_left, o_is_frame_start, o_audio};
  assign all_outs = {o_valid, o_audio, o_is_frame_start, o_is_left, o_validity, o_user,
                     o_control, o_parity_error, o_biphase_error, o_locked, o_overrun};

  spdif_sub_frame_decoder dut (
    .clk128           (clk128),
    .reset_n          (reset_n),
    .spdif            (spdif),
    .i_ready          (i_ready),
    .o_valid          (o_valid),
    .o_audio          (o_audio),
    .o_is_frame_start (o_is_frame_start),
    .o_is_left        (o_is_left),
    .o_validity       (o_validity),
    .o_user           (o_user),
    .o_control        (o_control),
    .o_parity_error   (o_parity_error),
    .o_biphase_error  (o_biphase_error),
    .o_locked         (o_locked),
    .o_overrun        (o_overrun),
    .o_state          (o_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk128 = ~clk128;

  always @(posedge clk128) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] word_of(input logic [1:0] pt, input logic [23:0] a,
                                           input logic v, input logic u, input logic c,
                                           input logic par, input logic bp);
    logic fs;
    logic left;
    fs   = (pt == PT_B);
    left = (pt != PT_W);
    return {bp, par, c, u, v, left, fs, a};
  endfunction

  // f[i] is half-cell i of the sub-frame; the preamble polarity follows the line level.
  task automatic build_frame(input logic [1:0] pt, input logic [23:0] a, input logic v,
                             input logic u, input logic c, output logic [63:0] f);
    logic [7:0]  pat;
    logic [27:0] pl;
    logic        lvl;
    case (pt)
      PT_B:    pat = 8'b11101000;
      PT_M:    pat = 8'b11100010;
      default: pat = 8'b11100100;
    endcase
    if (line_lvl) pat = ~pat;
    f = 64'd0;
    for (int i = 0; i < 8; i++) f[i] = pat[7-i];
    lvl = f[7];
    pl = {1'b0, c, u, v, a};
    pl[27] = ^pl[26:0];
    for (int s = 0; s < 28; s++) begin
      lvl = ~lvl;
      f[8+2*s] = lvl;
      if (pl[s]) lvl = ~lvl;
      f[9+2*s] = lvl;
    end
    line_lvl = lvl;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cells(input logic [63:0] f, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk128);
      spdif = f[i];
    end
  endtask

  task automatic send(input logic [1:0] pt, input logic [23:0] a, input logic v,
                      input logic u, input logic c, input logic expect_it, input logic fault);
    logic [63:0] f;
    build_frame(pt, a, v, u, c, f);
    // A glitch on slot 10's second half flips audio bit 6 and breaks the slot 11 boundary.
    if (fault) f[21] = ~f[21];
    if (expect_it)
      exp_q.push_back(word_of(pt, a ^ (fault ? 24'h000040 : 24'h0), v, u, c, fault, fault));
    drive_cells(f, 0, 63);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk128);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor_loop();
    logic [W-1:0] held;
    logic         held_v;
    held   = '0;
    held_v = 1'b0;
    forever begin
      @(negedge clk128);
      if (o_overrun) ovr_cnt++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_word: got %0h, required no word (cycle %0d)", dut_word, cyc);
        end else begin
          check("word", dut_word, exp_q.pop_front());
        end
        acc_cyc.push_back(cyc);
        held_v = 1'b0;
      end else if (o_valid) begin
        if (held_v) check("hold", dut_word, held);
        held   = dut_word;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, %0d words outstanding", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] f;
    int          fall_k;
    fork
      monitor_loop();
    join_none

    reset_n = 1'b0;
    i_ready = 1'b1;
    spdif   = 1'b0;
    repeat (3) @(negedge clk128);
    #1;
    check("reset_outputs", all_outs, 34'd0);
    check("reset_state", o_state, 2'd0);
    @(negedge clk128);
    reset_n = 1'b1;
    idle(5);

    // Back-to-back stream: lead-in, loopback words, then a glitched and a clean word.
    send(PT_W, 24'h0A5A5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("locked_0", o_locked, 1'b1);
    send(PT_B, 24'hFFFFF8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("locked_1", o_locked, 1'b1);
    send(PT_W, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("locked_2", o_locked, 1'b1);
    send(PT_M, 24'h987655, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("locked_3", o_locked, 1'b1);
    send(PT_M, 24'h5A5A5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    send(PT_W, 24'h00F00F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Line now held constant: lock must drop at the 10th edge after the last half-cell drive.
    fall_k = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk128);
      #1;
      if (!o_locked && fall_k == 0) fall_k = k;
    end
    check("lock_fall", fall_k, 10);

    if (acc_cyc.size() < 6) begin
      n_vec++;
      n_bad++;
      $display("FAIL spacing: got %0d words, required 6", acc_cyc.size());
    end else begin
      for (int i = 1; i < 6; i++) check("spacing", acc_cyc[i] - acc_cyc[i-1], 64);
    end

    idle(10);
    send(PT_W, 24'h3C3C3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("relock", o_locked, 1'b1);
    send(PT_M, 24'h00A00A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Stalled consumer across two sub-frames: first held, second dropped with overrun.
    idle(20);
    i_ready = 1'b0;
    send(PT_W, 24'h111111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(PT_M, 24'h222222, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    check("overrun_pulse", ovr_cnt, 1);
    i_ready = 1'b1;
    idle(3);

    // Acceptance on the same edge the next word completes: both delivered, no overrun.
    idle(20);
    i_ready = 1'b0;
    send(PT_W, 24'h333333, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(PT_M, 24'h444444, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    i_ready = 1'b1;
    idle(4);
    check("same_edge_no_overrun", ovr_cnt, 1);

    // Reset pulse in the middle of a sub-frame; the interrupted word is never delivered.
    idle(20);
    send(PT_W, 24'h555555, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("locked_pre_reset", o_locked, 1'b1);
    build_frame(PT_M, 24'h666666, 1'b0, 1'b0, 1'b0, f);
    drive_cells(f, 0, 29);
    reset_n = 1'b0;
    drive_cells(f, 30, 32);
    #1;
    check("midreset_outputs", all_outs, 34'd0);
    check("midreset_state", o_state, 2'd0);
    reset_n = 1'b1;
    drive_cells(f, 33, 63);
    send(PT_W, 24'h777777, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    send(PT_B, 24'h888888, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(6);

    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spdif_sub_frame_decoder.md
SPDIF_SUB_FRAME_DECODER -- requirements
Module: spdif_sub_frame_decoder

Interface
REQ-001 SHALL have ports: clk128  input  1  clock at 128 x fs, one biphase half-cell per cycle, same clock as spdif_sub_frame_encoder.
REQ-002 SHALL have reset_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have spdif  input  1  biphase-mark serial stream, half-cell aligned to clk128.
REQ-004 SHALL have o_valid  output  1  decoded sub-frame available.
REQ-005 SHALL have i_ready  input  1  consumer accepts the word when o_valid && i_ready.
REQ-006 SHALL have o_audio  output  24  audio sample (slot 4 = LSB, slot 27 = MSB).
REQ-007 SHALL have o_is_frame_start, o_is_left, o_validity, o_user, o_control  output  1 each  B preamble; B or M preamble; slots 28/29/30.
REQ-008 SHALL have o_parity_error, o_biphase_error  output  1 each  per-word error flags.
REQ-009 SHALL have o_locked  output  1  preamble timing acquired; o_overrun  output  1  one-cycle pulse, word lost.

Function
REQ-010 SHALL register spdif once; all decoding uses the registered sample and an 8-sample history shift register.
REQ-011 SHALL recognise preambles over 8 half-cells, oldest first, in either polarity: B = 11101000/00010111, M = 11100010/00011101, W = 11100100/00011011.
REQ-012 SHALL implement states HUNT, DATA, CHECK.
REQ-013 In HUNT, a preamble match SHALL enter DATA, set o_locked = 1, latch the preamble type, and clear the half-cell counter.
REQ-014 In DATA, the counter SHALL run 0..55 over slots 4..31; slot bit = 1 iff its two half-cells differ.
REQ-015 A slot whose first half-cell equals the preceding half-cell SHALL set the word's biphase error; decoding SHALL continue.
REQ-016 After half-cell 55, the word SHALL be assembled with o_parity_error = XOR of slots 4..31; the FSM SHALL then enter CHECK.
REQ-017 CHECK SHALL span exactly 8 half-cells and then test the history register.
  - Match: enter DATA with the new preamble type.
  - No match: clear o_locked, enter HUNT, and deliver no further words until relock.
REQ-018 Preamble spacing SHALL be exactly 64 half-cells; no drift tolerance.
REQ-019 The output word SHALL load on the second rising edge after the edge sampling slot 31's final half-cell, with o_valid = 1.
REQ-020 o_valid and all word fields SHALL hold stable until o_valid && i_ready; o_valid SHALL clear the next cycle unless a new word loads that same edge.
REQ-021 If a new word completes while o_valid = 1 and i_ready = 0, the SHALL retain the old word, drop the new one, and pulse o_overrun for one cycle.
REQ-022 A new word completing on the same edge as acceptance SHALL load normally, with no overrun.
REQ-023 Type sequencing (W after B/M) SHALL NOT be enforced; each word reports its own preamble.

Reset
REQ-024 While reset_n = 0, state SHALL be HUNT, counters and history SHALL be 0, and every output SHALL be 0.
REQ-025 Deasserting reset_n mid-stream SHALL require a fresh preamble before any word is output; partial sub-frames SHALL be discarded.

Verification
REQ-026 Loop back through spdif_sub_frame_encoder: 24'hFFFFF8, frame_start = 1, left = 1, U = 1, C = 1 -> o_audio = FFFFF8, o_is_frame_start = 1, o_is_left = 1, o_user = 1, o_control = 1, both error flags = 0.
REQ-027 Continue with 24'h123456 right, then 24'h987655 left, no frame start -> words arrive in order 64 cycles apart with matching flags; o_locked stays 1.
REQ-028 Invert one mid-cell half-cell of slot 10 -> that word has o_parity_error = 1 and an o_audio bit-6 mismatch; the next word is clean.
REQ-029 Hold i_ready = 0 across two sub-frames -> first word held, one-cycle o_overrun; after i_ready = 1, the first word is accepted.
REQ-030 Hold spdif constant after a sub-frame -> o_locked falls 8 cycles after the expected preamble start; relock occurs on the next encoder preamble.
REQ-031 Pulse reset_n low mid sub-frame -> all outputs 0; the first word after reset is the next complete sub-frame.
